cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

- Multi-cycle wide adder: reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area where a full-width lookahead tree is too large.
- Owns operand capture, nibble sequencing, carry chaining between nibbles and result holding under backpressure.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and ≥ 4.
- Derived `NCHUNK = WIDTH/4`: number of nibbles per operation.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: operands and `cin` are valid.
- `in_ready`  output  1: block can accept operands.
- `a`, `b`  input  WIDTH: operands.
- `cin`  input  1: carry into bit 0.
- `out_valid`  output  1: `sum`/`cout` are valid.
- `out_ready`  input  1: consumer accepts the result.
- `sum`  output  WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`  output  1: carry out of bit WIDTH-1.
- `busy`  output  1: high in RUN and DONE.
- `ovf`  output  1: signed overflow; present only with `CLA_SEQ_OVF_EN`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0, `busy`=0.
  - RUN: `in_ready`=0, `busy`=1.
  - DONE: `out_valid`=1, `in_ready`=0, `busy`=1.
- IDLE → RUN on `in_valid && in_ready`.
  - `a`, `b` and `cin` are latched into internal registers.
  - The carry register is loaded with `cin`.
  - Chunk index `idx` is set to 0.
  - `sum` is cleared to 0.
- Each RUN cycle processes nibble `idx` of the latched operands:
  - Per bit: g = a&b, p = a^b.
  - Carries: c1 = g0|p0·c0, and so on through c4, all two-level lookahead from the carry register, with no ripple inside the slice.
  - Nibble result p ^ {c3..c0} is written to `sum[4·idx+3:4·idx]`.
  - The carry register takes c4, and `idx` increments.
- RUN → DONE on the edge where `idx == NCHUNK-1`. The final c4 drives `cout`.
- DONE → IDLE on `out_valid && out_ready`. `sum`/`cout` keep their value until the next acceptance.
- Input ports are ignored outside the IDLE acceptance edge. Changes to `a`/`b`/`cin` during RUN have no effect.
- `idx` width is clog2(NCHUNK), minimum 1 bit. With `WIDTH`=4 the FSM spends exactly one cycle in RUN.
- `rst_n` low at any time forces IDLE immediately and asynchronously, aborting any operation in progress with no partial result emitted. Registers reset to:
  - `sum`=0, `cout`=0, `ovf`=0
  - carry register = 0, `idx`=0
  - `out_valid`=0, `busy`=0
- `in_ready` is decoded from state, so it reads 1 during reset.

## Timing
- Acceptance edge t0, then RUN edges t1..tNCHUNK.
- `out_valid` rises after edge tNCHUNK, i.e. NCHUNK cycles after acceptance (4 for `WIDTH`=16).
- Result handshake edge returns the FSM to IDLE. The earliest next acceptance is the following edge.
- Minimum initiation interval is NCHUNK+2 cycles.
- With `out_ready` held high, `out_valid` is high for exactly one cycle.
- Under backpressure, `out_valid`, `sum`, `cout` and `ovf` hold stable until `out_ready`.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- Macro `CLA_SEQ_OVF_EN`.
- Defined:
  - `ovf` port exists.
  - On the final RUN edge, `ovf` is set to c_in(MSB) ^ c_out(MSB), using the MSB carry-in from the last slice's c3.
  - `ovf` holds with `sum` and resets to 0.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan
- Carry across every nibble: `WIDTH`=16, a=0xFFFF, b=0x0001, cin=0 → after 4 cycles `sum`=0x0000, `cout`=1, `out_valid` for 1 cycle with `out_ready`=1.
- Plain add with carry-in: a=0x1234, b=0x4321, cin=1 → `sum`=0x5556, `cout`=0. Changing a/b during RUN does not alter the result.
- Backpressure: a=0x00FF, b=0x0F01, `out_ready` low for 3 cycles after `out_valid` → `sum`=0x1000 held stable, `in_ready`=0 throughout, IDLE on the cycle after `out_ready`=1.
- Reset mid-operation: assert `rst_n` low during RUN with `idx`=2 → all outputs reset immediately, `in_ready`=1. After release, a=0x0003, b=0x0004 → `sum`=0x0007 and no stale `out_valid`.
- Back-to-back: hold `in_valid`=1 with a new operand each acceptance → a new acceptance every 6 cycles; every result is correct against a reference sum, including 1000 random vectors.
- `CLA_SEQ_OVF_EN` defined:
  - 0x7FFF+0x0001 → `sum`=0x8000, `ovf`=1.
  - 0x8000+0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
  - 0x0001+0xFFFF → `ovf`=0, `cout`=1.

Source files
------------

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [3:0]       a_nib, b_nib, g, p;
  logic [4:0]       c;
  logic             last, accept;

  assign last   = (idx == IW'(NCHUNK - 1));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // Two-level lookahead: every carry is formed directly from g/p and the carry register.
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx == IW'(i)) sum[4*i +: 4] <= p ^ c[3:0];
      end
      carry_q <= c[4];
      idx     <= idx + IW'(1);
      if (last) begin
        cout <= c[4];
`ifdef CLA_SEQ_OVF_EN
        ovf  <= c[3] ^ c[4];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks for cla_seq_adder at WIDTH=16 (ovf checks when CLA_SEQ_OVF_EN is defined).
module tb_cla_seq_adder;

  localparam int W   = 16;
  localparam int NCH = W / 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at the negedge where out_valid is seen (or timeout).
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                                input bit scramble, output int lat);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc_last, nacc, nres;
    logic [W:0]   ref_full;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[8] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
`ifdef CLA_SEQ_OVF_EN
    check("reset_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; operands scrambled during RUN must not matter.
    for (int i = 0; i < 9; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, lat);
      check($sformatf("vec%0d_latency", i), lat, NCH);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].s);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].co);
`ifdef CLA_SEQ_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
`endif
      check($sformatf("vec%0d_busy_done", i), busy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_valid_one_cycle", i), out_valid, 0);
      check($sformatf("vec%0d_back_idle", i), in_ready, 1);
    end

    // Backpressure: result must hold for three stalled cycles.
    out_ready = 1'b0;
    start_and_wait(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    check("bp_latency", lat, NCH);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid_held", out_valid, 1);
      check("bp_sum_held", sum, 16'h1000);
      check("bp_cout_held", cout, 0);
      check("bp_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", out_valid, 0);
    check("bp_released_idle", in_ready, 1);

    // Reset while idx==2: partial sum must vanish immediately.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_sum", sum, 0);
    check("rst_mid_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_no_stale_valid", out_valid, 0);
    start_and_wait(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    check("rst_after_latency", lat, NCH);
    check("rst_after_sum", sum, 16'h0007);
    check("rst_after_cout", cout, 0);
    @(negedge clk);

    // Back-to-back random traffic with in_valid held high.
    in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nres = 0; cyc_last = 0; ref_full = '0; ra = '0; rb = '0;
    for (int cyc = 0; cyc < 1000 * 6 + 20; cyc++) begin
      if (out_valid) begin
        check("b2b_sum", sum, ref_full[W-1:0]);
        check("b2b_cout", cout, ref_full[W]);
`ifdef CLA_SEQ_OVF_EN
        check("b2b_ovf", ovf, (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]));
`endif
        nres++;
      end
      if (in_ready && nacc < 1000) begin
        if (nacc > 0) check("b2b_interval", cyc - cyc_last, 6);
        cyc_last = cyc;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        a = ra; b = rb; cin = rc;
        nacc++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_result_count", nres, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
